pipeline_stall_ctrl: RTL

Central stall and sequencing controller for the five-stage pipeline. It drives the shared `stop_all` bus that every stage register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) samples. It converts load-use and multi-cycle stall requests into per-stage hold/bubble patterns, and it sequences the iterative divider through a start/ready/annul handshake with a watchdog. It sits beside the datapath, takes requests from ID and EX, and returns `stop_all` to all pipeline registers in the same cycle.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 20 ++
 rtl/pipeline_stall_ctrl_stall_counter.sv | 25 ++
 rtl/pipeline_stall_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared stall-bus constants for the five-stage pipeline.
// Stop patterns are listed MSB (WB) to LSB (PC).
package pipeline_stall_ctrl_pkg;

  localparam int StopAllBus = 6;
  localparam logic Stop = 1'b1;
  localparam logic NoStop = 1'b0;
  localparam logic ResetEnable = 1'b0;
  localparam int DivTimeoutDefault = 40;

  typedef logic [StopAllBus-1:0] stop_all_t;

  localparam stop_all_t StopNone =
    {StopAllBus{NoStop}};
  localparam stop_all_t StopToId =
    {{3{NoStop}}, {3{Stop}}};
  localparam stop_all_t StopToEx =
    {{2{NoStop}}, {4{Stop}}};

endpackage

// File: rtl/pipeline_stall_ctrl_stall_counter.sv
// Saturating event counter with synchronous clear.
// Clear wins over the increment.
module stall_counter
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (reset == ResetEnable) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall controller: drives stop_all to every stage
// register and sequences the iterative divider.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = DivTimeoutDefault,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   id_stop_request,
  input  logic                   ex_stop_request,
  input  logic                   ex_div_request,
  input  logic                   div_ready,
  input  logic                   stall_count_clear,
  output logic [StopAllBus-1:0]  stop_all,
  output logic                   div_start,
  output logic                   div_annul,
  output logic                   div_timeout_error,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] Limit =
    CNT_W'(DIV_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN,
    DIV_WAIT,
    DIV_DONE
  } state_e;

  state_e          state;
  logic [CNT_W-1:0] wait_cnt;
  logic            in_wait;
  logic            at_limit;
  stop_all_t       stop_dec;

  assign in_wait  = (state == DIV_WAIT);
  assign at_limit = (wait_cnt == Limit);

  // Annul beats start so the two pulses never overlap.
  assign div_annul = in_wait &
    (flush | (at_limit & ~div_ready));
  assign div_start = in_wait &
    (wait_cnt == '0) & ~div_annul;

  always_comb begin
    stop_dec = StopNone;
    unique case (state)
      RUN: begin
        if (flush)
          stop_dec = StopNone;
        else if (ex_div_request)
          stop_dec = StopToEx;
        else if (ex_stop_request)
          stop_dec = StopToEx;
        else if (id_stop_request)
          stop_dec = StopToId;
      end
      DIV_WAIT:
        stop_dec = flush ? StopNone : StopToEx;
      DIV_DONE:
        stop_dec = StopNone;
      default:
        stop_dec = StopNone;
    endcase
  end

  assign stop_all = (reset == ResetEnable)
    ? StopNone : stop_dec;

  always_ff @(posedge clock or negedge reset) begin
    if (reset == ResetEnable) begin
      state             <= RUN;
      wait_cnt          <= '0;
      div_timeout_error <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          wait_cnt <= '0;
          if (!flush && ex_div_request)
            state <= DIV_WAIT;
        end
        DIV_WAIT: begin
          if (flush) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (div_ready) begin
            state    <= DIV_DONE;
            wait_cnt <= '0;
          end else if (at_limit) begin
            state             <= RUN;
            wait_cnt          <= '0;
            div_timeout_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DIV_DONE: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  stall_counter #(
    .W (STALL_CNT_W)
  ) u_stall_counter (
    .clock (clock),
    .reset (reset),
    .clear (stall_count_clear),
    .inc   (stop_all[0]),
    .count (stall_cycles)
  );

endmodule
